// File: rtl/aes_pkg.sv
// Shared AES constants, S-box tables and GF(2^8) helpers, plus the
// inverse-cipher FSM state type.
package aes_pkg;

    localparam int NR    = 14;
    localparam int BLK_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        HOLD  = 2'd3
    } inv_state_e;

    // Entry 0 sits in the most significant byte of each table.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(b)));
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        logic [7:0] x2, x8;
        x2 = xtime(b);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        logic [7:0] x4, x8;
        x4 = xtime(xtime(b));
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] state_i,
    input  logic [BLK_W-1:0] rkey_i,
    input  logic             final_i,
    output logic [BLK_W-1:0] state_o
);

    // Index 0 is the most significant byte, i.e. AES byte 0.
    logic [0:15][7:0] s_in, s_sub, s_ark, s_mix;

    assign s_in  = state_i;
    assign s_ark = s_sub ^ rkey_i;

    for (genvar c = 0; c < 4; c++) begin : g_col
        // Row r rotates right by r columns.
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign s_sub[4*c+r] = inv_sbox(s_in[4*((c+4-r)%4)+r]);
        end

        assign s_mix[4*c+0] = gmul14(s_ark[4*c+0]) ^ gmul11(s_ark[4*c+1]) ^
                              gmul13(s_ark[4*c+2]) ^ gmul9 (s_ark[4*c+3]);
        assign s_mix[4*c+1] = gmul9 (s_ark[4*c+0]) ^ gmul14(s_ark[4*c+1]) ^
                              gmul11(s_ark[4*c+2]) ^ gmul13(s_ark[4*c+3]);
        assign s_mix[4*c+2] = gmul13(s_ark[4*c+0]) ^ gmul9 (s_ark[4*c+1]) ^
                              gmul14(s_ark[4*c+2]) ^ gmul11(s_ark[4*c+3]);
        assign s_mix[4*c+3] = gmul11(s_ark[4*c+0]) ^ gmul13(s_ark[4*c+1]) ^
                              gmul9 (s_ark[4*c+2]) ^ gmul14(s_ark[4*c+3]);
    end

    assign state_o = final_i ? s_ark : s_mix;

endmodule

// File: rtl/aes256_inv_cipher.sv
// Iterative AES-256 inverse cipher, one round per clock, one block in flight.
// Round keys come unlatched from the key-expansion block and must stay stable.
module aes256_inv_cipher
    import aes_pkg::*;
#(
    parameter int NR = 14
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [127:0]               ciphertext_i,
    input  logic [128*(NR+1)-1:0]      rkeys_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [127:0]               plaintext_o
);

    logic [NR:0][127:0] rk;
    inv_state_e         st_q;
    logic [127:0]       state_q;
    logic [127:0]       rkey;
    logic [127:0]       rnd_out;
    logic [3:0]         rnd_q;

    assign rk   = rkeys_i;
    assign rkey = (st_q == FINAL) ? rk[0] : rk[rnd_q];

    aes_inv_round u_round (
        .state_i (state_q),
        .rkey_i  (rkey),
        .final_i (st_q == FINAL),
        .state_o (rnd_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q        <= IDLE;
            state_q     <= '0;
            rnd_q       <= '0;
            plaintext_o <= '0;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
        end else begin
            case (st_q)
                IDLE: begin
                    if (in_valid_i && in_ready_o) begin
                        state_q    <= ciphertext_i ^ rk[NR];
                        rnd_q      <= 4'(NR - 1);
                        in_ready_o <= 1'b0;
                        st_q       <= ROUND;
                    end
                end
                ROUND: begin
                    state_q <= rnd_out;
                    // Counter parks at 1; FINAL selects rk[0] on its own.
                    if (rnd_q == 4'd1) st_q  <= FINAL;
                    else               rnd_q <= rnd_q - 4'd1;
                end
                FINAL: begin
                    plaintext_o <= rnd_out;
                    out_valid_o <= 1'b1;
                    st_q        <= HOLD;
                end
                HOLD: begin
                    if (out_valid_o && out_ready_i) begin
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                        st_q        <= IDLE;
                    end
                end
                default: begin
                    out_valid_o <= 1'b0;
                    in_ready_o  <= 1'b1;
                    st_q        <= IDLE;
                end
            endcase
        end
    end

endmodule
